// File: rtl/pwm_wta_engine.sv
// PWM winner-take-all engine: ranks channels by the time their pulse falls.
// Internal generators or external PWM feed a common synchronizer, edge detector and counters.
//
//   state | meaning
//   IDLE  | waiting for i_start, results held
//   RUN   | generators active, falls ranked, timer running
//   DONE  | one-cycle completion, o_done asserted
module pwm_wta_engine #(
  parameter int N_CH  = 8,
  parameter int CNT_W = 12,
  parameter int K_W   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic                  i_mode,
  input  logic [K_W-1:0]        i_k,
  input  logic [N_CH-1:0]       i_sel_ext,
  input  logic [N_CH-1:0]       i_ext_pwm,
  input  logic [N_CH*CNT_W-1:0] i_pulse_width,
  output logic [N_CH-1:0]       o_pwm,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_timeout,
  output logic [N_CH-1:0]       o_nn,
  output logic [N_CH-1:0]       o_knn,
  output logic [N_CH*CNT_W-1:0] o_count
);

  localparam int TALLY_W = $clog2(N_CH + 1);
  localparam int CMP_W   = ((TALLY_W > K_W) ? TALLY_W : K_W) + 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t state, state_nxt;
  logic   busy_d, done_d, busy_q, done_q;

  logic                mode_q;
  logic [K_W-1:0]      k_q;
  logic [N_CH-1:0]     sel_q;
  logic [CNT_W-1:0]    rem_q [N_CH];
  logic [CNT_W-1:0]    cnt_q [N_CH];
  logic [N_CH-1:0]     pwm_q, sync1_q, sync2_q, prev_q;
  logic [N_CH-1:0]     fallen_q, nn_q, knn_q;
  logic [TALLY_W-1:0]  tally_q;
  logic [CNT_W-1:0]    tmr_q;
  logic                timeout_q;

  logic [N_CH-1:0]     src, new_fall, fallen_nxt;
  logic [TALLY_W-1:0]  fall_pc, tally_nxt;
  logic [K_W-1:0]      keff;
  logic                tally_lt_keff, knn_full, tmr_hit, search_end, start_acc;

  assign start_acc = (state == IDLE) && i_start;

  // Internal channels go through the same synchronizer as external ones.
  assign src        = (sel_q & i_ext_pwm) | (~sel_q & pwm_q);
  assign new_fall   = (state == RUN) ? (prev_q & ~sync2_q & ~fallen_q) : '0;
  assign fallen_nxt = fallen_q | new_fall;

  always_comb begin
    fall_pc = '0;
    for (int i = 0; i < N_CH; i++) fall_pc = fall_pc + TALLY_W'(new_fall[i]);
  end

  assign tally_nxt     = tally_q + fall_pc;
  assign keff          = (k_q == '0) ? K_W'(1) : k_q;
  assign tally_lt_keff = CMP_W'(tally_q) < CMP_W'(keff);
  assign knn_full      = CMP_W'(tally_nxt) >= CMP_W'(keff);
  assign tmr_hit       = (tmr_q == '0);
  assign search_end    = tmr_hit | (mode_q ? (&fallen_nxt) : knn_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (i_start) state_nxt = RUN;
      RUN:     if (search_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy_d = (state_nxt != IDLE);
    done_d = (state_nxt == DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q    <= 1'b0;
      k_q       <= '0;
      sel_q     <= '0;
      pwm_q     <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
      fallen_q  <= '0;
      nn_q      <= '0;
      knn_q     <= '0;
      tally_q   <= '0;
      tmr_q     <= '0;
      timeout_q <= 1'b0;
      for (int i = 0; i < N_CH; i++) begin
        rem_q[i] <= '0;
        cnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= src;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      if (start_acc) begin
        mode_q    <= i_mode;
        k_q       <= i_k;
        sel_q     <= i_sel_ext;
        sync1_q   <= '0;
        sync2_q   <= '0;
        prev_q    <= '0;
        fallen_q  <= '0;
        nn_q      <= '0;
        knn_q     <= '0;
        tally_q   <= '0;
        tmr_q     <= CNT_MAX;
        timeout_q <= 1'b0;
        for (int i = 0; i < N_CH; i++) begin
          rem_q[i] <= i_pulse_width[i*CNT_W +: CNT_W];
          pwm_q[i] <= (i_pulse_width[i*CNT_W +: CNT_W] != '0);
          cnt_q[i] <= '0;
        end
      end else if (state == RUN) begin
        // rem_q counts the high cycles still owed; generator stops when the search ends.
        for (int i = 0; i < N_CH; i++) begin
          if (state_nxt == RUN) begin
            if (rem_q[i] != '0) rem_q[i] <= rem_q[i] - CNT_W'(1);
            pwm_q[i] <= (rem_q[i] > CNT_W'(1));
          end else begin
            rem_q[i] <= '0;
            pwm_q[i] <= 1'b0;
          end
          if (sync2_q[i] && (cnt_q[i] != CNT_MAX)) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
        end
        fallen_q <= fallen_nxt;
        if (tally_q == '0) nn_q <= nn_q | new_fall;
        if (tally_lt_keff) knn_q <= knn_q | new_fall;
        tally_q <= tally_nxt;
        if (!tmr_hit) tmr_q <= tmr_q - CNT_W'(1);
        if (tmr_hit) timeout_q <= 1'b1;
      end
    end
  end

  assign o_pwm     = pwm_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;
  assign o_timeout = timeout_q;
  assign o_nn      = nn_q;
  assign o_knn     = knn_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_count
    assign o_count[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: doc/pwm_wta_engine.md
PWM_WTA_ENGINE -- requirements
Module: pwm_wta_engine

Interface
REQ-001 SHALL have parameter N_CH, default 8: number of PWM channels, 2..16.
REQ-002 SHALL have parameter CNT_W, default 12: pulse-width and counter width.
REQ-003 SHALL have parameter K_W, default 3: width of the k select.
REQ-004 SHALL use one clock; reset is asynchronous and active-high.
REQ-005 SHALL have these ports:
- clk  in  1  clock
- rst  in  1  async active-high reset
- i_start  in  1  start a search
- i_mode  in  1  0 = stop after K winners; 1 = run until all channels fall
- i_k  in  K_W  number of nearest neighbours K
- i_sel_ext  in  N_CH  per channel: 1 = external PWM, 0 = internal generator
- i_ext_pwm  in  N_CH  external asynchronous PWM inputs
- i_pulse_width  in  N_CH*CNT_W  internal pulse widths; channel i at bits [(i+1)*CNT_W-1 -: CNT_W]
- o_pwm  out  N_CH  internal generator outputs
- o_busy  out  1  search in progress
- o_done  out  1  one-cycle completion pulse
- o_timeout  out  1  last search ended on timeout
- o_nn  out  N_CH  first-fall winner mask
- o_knn  out  N_CH  first-K winner mask
- o_count  out  N_CH*CNT_W  measured high time per channel, same packing as i_pulse_width

Function
REQ-006 SHALL implement the FSM IDLE -> RUN -> DONE -> IDLE.
REQ-007 IDLE: i_start=1 moves to RUN next cycle; capture i_mode, i_k, i_sel_ext and i_pulse_width; clear counts, masks, tally, timer and o_timeout.
REQ-008 i_start SHALL be ignored in RUN and DONE; inputs changing during RUN SHALL have no effect.
REQ-009 Internal generator i: o_pwm[i]=1 for exactly pw[i] cycles starting the first RUN cycle, then 0; pw=0 never goes high.
REQ-010 Selected source per channel SHALL pass through a 2-flop synchronizer; internal channels also use it, for equal latency.
REQ-011 Falling edge SHALL be detected as synced-previous & ~synced, in RUN only.
REQ-012 Per-channel counter SHALL increment each RUN cycle while the synced level is high, and SHALL saturate at 2^CNT_W-1; internal channel result o_count[i]=pw[i].
REQ-013 Each channel SHALL be ranked at most once, on its first fall; later edges are ignored.
REQ-014 Keff = max(K,1), with K taken from the captured i_k.
REQ-015 New fallers SHALL set o_nn when tally==0, and o_knn when tally<Keff; simultaneous fallers all set the masks (ties included, even if this exceeds Keff).
REQ-016 tally (width clog2(N_CH+1)) SHALL add the popcount of new fallers each cycle.
REQ-017 A free-running RUN timer SHALL count cycles; reaching 2^CNT_W-1 sets o_timeout and ends the search.
REQ-018 Termination: mode 0 ends when tally>=Keff; mode 1 ends when all N_CH channels have fallen; either mode also ends on timeout. Any of these moves to DONE on the next cycle.
REQ-019 A falling edge in the terminating cycle SHALL be ranked.
REQ-020 DONE SHALL last exactly one cycle, with o_done=1 there, then return to IDLE.
REQ-021 o_busy=1 in RUN and DONE.
REQ-022 o_nn, o_knn, o_count and o_timeout SHALL be held in IDLE until the next accepted start.
REQ-023 All outputs SHALL be registered.

Reset
REQ-024 rst SHALL force IDLE and zero all outputs, counters, synchronizers, tally and timer immediately, including mid-RUN; the search is abandoned with no o_done.
REQ-025 The first i_start after rst deasserts SHALL be accepted normally.

Verification (N_CH=8, CNT_W=12)
REQ-026 Mode 0, K=3, internal pw={40,10,70,20,80,30,60,50} -> o_nn=0x02, o_knn=0x2A, o_done once, o_timeout=0, o_count[1]=10.
REQ-027 Mode 1, same widths, K=3 -> done after the channel-4 fall (pw=80); all o_count equal pw; o_knn=0x2A.
REQ-028 Tie: pw ch0=ch5=15, others 100, K=1 -> o_nn=0x21, o_knn=0x21.
REQ-029 Mode 1, ch3 pw=0 -> o_timeout=1 at timer 4095, ch3 absent from masks, o_count[3]=0.
REQ-030 External ch7 (i_sel_ext=0x80) pulse of 25 clk, K=0 -> treated as K=1; ch7 counted 25±1; i_start during RUN ignored.
REQ-031 rst pulsed mid-RUN -> outputs 0, no o_done; the next start completes normally.
